// File: rtl/decoder_pkg.sv
// Shared constants and types for the registered 2-to-4 one-hot decoder.
package decoder_pkg;

  localparam int DEC_IN_W  = 2;
  localparam int DEC_OUT_W = 2 ** DEC_IN_W;

  typedef logic [DEC_OUT_W-1:0] sel_t;

  // Output width of a one-hot decoder for a given index width.
  function automatic int dec_out_w(input int in_w);
    return 2 ** in_w;
  endfunction

endpackage

// File: rtl/decoder_core.sv
// Purely combinational en/w -> one-hot decode; an unknown or illegal index decodes to zero.
module decoder_core
  import decoder_pkg::*;
#(
  parameter int IN_W  = DEC_IN_W,
  parameter int OUT_W = dec_out_w(IN_W)
) (
  input  logic            en,
  input  logic [IN_W-1:0] w,
  output logic [OUT_W-1:0] onehot,
  output logic            hit
);

  // An if with an X condition takes the else branch, so X/Z on w or en leaves the vector zero.
  always_comb begin
    onehot = '0;
    for (int k = 0; k < OUT_W; k++) begin
      if (en && (w == IN_W'(k))) begin
        onehot[k] = 1'b1;
      end
    end
  end

  assign hit = |onehot;

endmodule

// File: rtl/decoder_2x4_en.sv
// Registered one-hot decoder with enable, valid flag and optional active-low outputs.
module decoder_2x4_en
  import decoder_pkg::*;
#(
  parameter int IN_W       = DEC_IN_W,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [IN_W-1:0]       w,
  output logic [(2**IN_W)-1:0]  y,
  output logic                  valid
);

  localparam int OUT_W = dec_out_w(IN_W);

  logic [OUT_W-1:0] onehot;
  logic             hit;
  logic [OUT_W-1:0] y_reg;
  logic             valid_reg;

  decoder_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .en     (en),
    .w      (w),
    .onehot (onehot),
    .hit    (hit)
  );

  // Polarity is applied before the register so the outputs come straight off flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_reg     <= {OUT_W{ACTIVE_LOW}};
      valid_reg <= ACTIVE_LOW;
    end else begin
      y_reg     <= onehot ^ {OUT_W{ACTIVE_LOW}};
      valid_reg <= hit ^ ACTIVE_LOW;
    end
  end

  assign y     = y_reg;
  assign valid = valid_reg;

endmodule

// File: tb/tb_decoder_2x4_en.sv
// Self-checking bench: directed plan plus random stimulus against an arithmetic reference model.
module tb_decoder_2x4_en;
  import decoder_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] w;
  sel_t       y_hi;
  logic       valid_hi;
  sel_t       y_lo;
  logic       valid_lo;

  int n_checks = 0;
  int n_errors = 0;

  decoder_2x4_en #(.IN_W(2), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .w     (w),
    .y     (y_hi),
    .valid (valid_hi)
  );

  decoder_2x4_en #(.IN_W(2), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .w     (w),
    .y     (y_lo),
    .valid (valid_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: select = 2^w when enabled, nothing otherwise; active-low is the bitwise complement.
  task automatic check_model(input string tag, input logic e, input int idx);
    int exp_sel;
    exp_sel = e ? (1 << idx) : 0;
    check({tag, ".y"},        32'(y_hi),     32'(exp_sel));
    check({tag, ".valid"},    32'(valid_hi), 32'(e));
    check({tag, ".y_lo"},     32'(y_lo),     32'(15 - exp_sel));
    check({tag, ".valid_lo"}, 32'(valid_lo), 32'(!e));
    $display("txn %s en=%0d w=%0d y=%b valid=%0d y_lo=%b valid_lo=%0d",
             tag, e, idx, y_hi, valid_hi, y_lo, valid_lo);
  endtask

  // Drive inputs just after an edge, then check just after the following edge.
  task automatic step(input string tag, input logic e, input int idx);
    en = e;
    w  = 2'(idx);
    @(posedge clk);
    #1;
    check_model(tag, e, idx);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".y"},        32'(y_hi),     32'h0);
    check({tag, ".valid"},    32'(valid_hi), 32'h0);
    check({tag, ".y_lo"},     32'(y_lo),     32'hf);
    check({tag, ".valid_lo"}, 32'(valid_lo), 32'h1);
    $display("txn %s reset y=%b valid=%0d y_lo=%b valid_lo=%0d",
             tag, y_hi, valid_hi, y_lo, valid_lo);
  endtask

  initial begin
    int e_r;
    int w_r;
    rst = 1'b0;
    en  = 1'b1;
    w   = 2'd2;
    #1;
    rst = 1'b1;
    #1;
    check_reset("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst_hold");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_model("rst_release", 1'b1, 2);

    step("disabled", 1'b0, 3);
    for (int i = 0; i < 4; i++) step($sformatf("sweep%0d", i), 1'b1, i);

    step("drop_a", 1'b1, 2);
    step("drop_b", 1'b0, 2);
    step("drop_c", 1'b1, 3);

    // Async reset pulse strictly between two clock edges.
    #3;
    rst = 1'b1;
    #1;
    check_reset("rst_mid");
    #1;
    rst = 1'b0;
    step("resume", 1'b1, 1);

    for (int i = 0; i < 300; i++) begin
      e_r = int'($urandom_range(0, 3) != 0);
      w_r = int'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        check_reset($sformatf("rnd_rst%0d", i));
        rst = 1'b0;
      end
      step($sformatf("rnd%0d", i), e_r[0], w_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/decoder_2x4_en.md
Name: decoder_2x4_en

Overview:
- Registered 2-to-4 one-hot decoder with active-high enable.
- Drives a one-hot select vector y from a binary index w; all outputs go low when disabled.
- Used as a select or chip-enable generator inside synchronous datapaths.
- Output is registered to give a clean, glitch-free select with a fixed 1-cycle latency.

Parameters:
- IN_W, 2, width of the binary index w; output width OUT_W = 2**IN_W (4 by default).
- ACTIVE_LOW, 0, when 1 the y and valid outputs are inverted at the register output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  decode enable, active-high.
- w  input  IN_W  binary select index.
- y  output  OUT_W  registered one-hot decode, LSB-first: y[k]=1 iff w==k and en==1.
- valid  output  1  registered; 1 when y holds an active (enabled) decode.

Behaviour:
- Reset:
  - rst high asynchronously forces y to all-zero and valid to 0 (all-ones and 1 when ACTIVE_LOW=1).
  - Outputs hold that value while rst is high.
  - Release is synchronous in effect: the first decode is captured on the first rising clk edge with rst low.
- Decode function: next_y = en ? (1 << w) : 0; next_valid = en.
- Default mapping:
  - w=00 -> 0001; w=01 -> 0010; w=10 -> 0100; w=11 -> 1000.
  - en=0 -> 0000 regardless of w.
- Latency:
  - y and valid update on the rising clk edge following the input change; exactly 1-cycle latency.
  - No combinational path from inputs to outputs.
- en and w are sampled on the same edge; a simultaneous change of both takes effect together.
- No state beyond the output register; back-to-back changes every cycle are tracked exactly.
- Output is always one-hot or zero. No X may propagate: any w value not a legal 0..OUT_W-1 index (e.g. X/Z in simulation) yields all-zero with valid=0.
- ACTIVE_LOW=1: stored values are inverted (disabled = all-ones, w=01 enabled -> 1101).
- Reset asserted mid-operation clears outputs immediately, independent of clk.

Decomposition:
- Shared package decoder_pkg:
  - constant DEC_IN_W = 2.
  - function or constant for OUT_W = 2**DEC_IN_W.
  - typedef of the one-hot select vector.
- One natural sub-module, decoder_core: purely combinational en/w -> one-hot vector.
- Top level adds the register stage, the polarity option and the valid flag.

Test Plan:
- Reset: rst=1 with en=1, w=10 -> y=0000, valid=0 immediately, no clock needed; after release and one edge -> y=0100.
- Disabled: en=0, w=11 -> after the next edge y=0000, valid=0.
- Full sweep, en=1, w=00, 01, 10, 11 on consecutive cycles -> y=0001, 0010, 0100, 1000, each one cycle after its input; valid=1 throughout.
- Enable drop: en=1, w=10 (y=0100), then en=0 with w held at 10 -> next edge y=0000; then en=1, w=11 -> y=1000.
- Async reset mid-stream: while y=1000, pulse rst between clock edges -> y=0000 at once; decoding resumes on the first edge after release.
- ACTIVE_LOW=1 build: en=0 -> y=1111; en=1, w=01 -> y=1101, valid=0.
